// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control, program-loader write port and IF/ID outputs.
interface if_stage_if #(
    parameter int ADDR_W = 8
);
    logic              i_stall;
    logic              i_branch_taken;
    logic [31:0]       i_branch_target;
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic [31:0]       i_load_data;
    logic [31:0]       o_pc;
    logic [31:0]       o_next_pc;
    logic [31:0]       o_instruction;
    logic              o_halted;

    modport master (
        output i_stall, i_branch_taken, i_branch_target,
        output i_load_en, i_load_addr, i_load_data,
        input  o_pc, o_next_pc, o_instruction, o_halted
    );

    modport slave (
        input  i_stall, i_branch_taken, i_branch_target,
        input  i_load_en, i_load_addr, i_load_data,
        output o_pc, o_next_pc, o_instruction, o_halted
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, loader-writable instruction memory and IF/ID register.
// Optional halt-on-0xFFFFFFFF detection is enabled by defining IF_HALT_DETECT_EN.
module if_stage #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    logic [31:0]       imem_r [IMEM_DEPTH];
    logic [31:0]       pc_r;
    logic [31:0]       next_pc_r;
    logic [31:0]       instr_r;
    logic              halted_r;
    halt_state_t       state_r;
    halt_state_t       state_next_s;

    logic [ADDR_W-1:0] fetch_idx_s;
    logic [31:0]       fetch_word_s;
    logic [31:0]       pc_plus4_s;
    logic              halt_hit_s;
    logic              halted_s;
    logic [31:0]       pc_next_s;
    logic [31:0]       next_pc_next_s;
    logic [31:0]       instr_next_s;

    // Byte offset ignored; upper PC bits wrap modulo the memory depth.
    assign fetch_idx_s  = pc_r[ADDR_W+1:2];
    assign fetch_word_s = imem_r[fetch_idx_s];
    assign pc_plus4_s   = pc_r + 32'd4;
    assign halted_s     = (state_r == ST_HALTED);

    // Loader write port; contents deliberately survive reset. Reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (bus.i_load_en) begin
            imem_r[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // Halt FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Halt FSM next state: only an unstalled, unredirected fetch of all-ones halts.
    always_comb begin
        state_next_s = state_r;
        halt_hit_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
`ifdef IF_HALT_DETECT_EN
                if (!bus.i_branch_taken && !bus.i_stall && (fetch_word_s == 32'hFFFF_FFFF)) begin
                    halt_hit_s   = 1'b1;
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
`else
                state_next_s = ST_RUN;
`endif
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // PC and IF/ID next values: branch > stall/halted > halt entry > sequential fetch.
    always_comb begin
        pc_next_s      = pc_r;
        next_pc_next_s = next_pc_r;
        instr_next_s   = instr_r;
        if (bus.i_branch_taken && !halted_s) begin
            pc_next_s      = {bus.i_branch_target[31:2], 2'b00};
            next_pc_next_s = 32'd0;
            instr_next_s   = 32'd0;
        end else if (bus.i_stall || halted_s) begin
            pc_next_s      = pc_r;
            next_pc_next_s = next_pc_r;
            instr_next_s   = instr_r;
        end else if (halt_hit_s) begin
            pc_next_s      = pc_r;
            next_pc_next_s = 32'd0;
            instr_next_s   = 32'd0;
        end else begin
            pc_next_s      = pc_plus4_s;
            next_pc_next_s = pc_plus4_s;
            instr_next_s   = fetch_word_s;
        end
    end

    // PC, IF/ID and halted-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= 32'd0;
            next_pc_r <= 32'd0;
            instr_r   <= 32'd0;
            halted_r  <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            next_pc_r <= next_pc_next_s;
            instr_r   <= instr_next_s;
            halted_r  <= (state_next_s == ST_HALTED);
        end
    end

    assign bus.o_pc          = pc_r;
    assign bus.o_next_pc     = next_pc_r;
    assign bus.o_instruction = instr_r;
    assign bus.o_halted      = halted_r;
endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage; expectations adapt to IF_HALT_DETECT_EN.
module tb_if_stage;
`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    if_stage_if #(.ADDR_W(8)) bus ();

    if_stage #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] target;
        logic        ld;
        logic [7:0]  ld_addr;
        logic [31:0] ld_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_halt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] target, input logic ld,
                                input logic [7:0] ld_addr, input logic [31:0] ld_data,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_npc, input logic e_halt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.target = target;
        v.ld = ld; v.ld_addr = ld_addr; v.ld_data = ld_data;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_npc = e_npc; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_npc, input logic e_halt);
        check({tag, ".pc"},     bus.o_pc,          e_pc);
        check({tag, ".instr"},  bus.o_instruction, e_instr);
        check({tag, ".nextpc"}, bus.o_next_pc,     e_npc);
        check({tag, ".halted"}, {31'd0, bus.o_halted}, {31'd0, e_halt});
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] target,
                         input logic ld, input logic [7:0] ld_addr, input logic [31:0] ld_data);
        reset               = rst;
        bus.i_stall         = stall;
        bus.i_branch_taken  = br;
        bus.i_branch_target = target;
        bus.i_load_en       = ld;
        bus.i_load_addr     = ld_addr;
        bus.i_load_data     = ld_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, addr, data);
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
        step();

        // Program load happens while reset is held.
        preload(8'd0,   32'h2001_0005);
        preload(8'd1,   32'h2002_0003);
        preload(8'd2,   32'h0022_1820);
        preload(8'd3,   32'hFFFF_FFFF);
        preload(8'd5,   32'h5555_5555);
        preload(8'd16,  32'h1111_1111);
        preload(8'd17,  32'h2222_2222);
        preload(8'd255, 32'hBEEF_00FF);
        check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0);

        vecs[0]  = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'd4,  32'h2001_0005, 32'd4,  0);
        vecs[1]  = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'd8,  32'h2002_0003, 32'd8,  0);
        vecs[2]  = mk(0,1,0,32'd0,   0,8'd0,32'd0, 32'd8,  32'h2002_0003, 32'd8,  0);
        vecs[3]  = mk(0,1,0,32'd0,   0,8'd0,32'd0, 32'd8,  32'h2002_0003, 32'd8,  0);
        vecs[4]  = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'd12, 32'h0022_1820, 32'd12, 0);
        vecs[5]  = HALT_EN ? mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'd12,    32'd0,         32'd0,  1)
                           : mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'd16,    32'hFFFF_FFFF, 32'd16, 0);
        vecs[6]  = HALT_EN ? mk(0,0,1,32'h100, 0,8'd0,32'd0, 32'd12,    32'd0,         32'd0,  1)
                           : mk(0,0,1,32'h100, 0,8'd0,32'd0, 32'h100,   32'd0,         32'd0,  0);
        vecs[7]  = mk(1,0,1,32'h100, 0,8'd0,32'd0, 32'd0,   32'd0,         32'd0,   0);
        vecs[8]  = mk(0,1,1,32'h43,  0,8'd0,32'd0, 32'h40,  32'd0,         32'd0,   0);
        vecs[9]  = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'h44,  32'h1111_1111, 32'h44,  0);
        vecs[10] = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'h48,  32'h2222_2222, 32'h48,  0);
        vecs[11] = mk(0,0,1,32'h20,  0,8'd0,32'd0, 32'h20,  32'd0,         32'd0,   0);
        vecs[12] = mk(1,0,0,32'd0,   1,8'd40,32'hCAFE_0040, 32'd0, 32'd0,  32'd0,   0);
        vecs[13] = mk(0,0,1,32'hA0,  0,8'd0,32'd0, 32'hA0,  32'd0,         32'd0,   0);
        vecs[14] = mk(0,0,0,32'd0,   0,8'd0,32'd0, 32'hA4,  32'hCAFE_0040, 32'hA4,  0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].target,
                  vecs[i].ld, vecs[i].ld_addr, vecs[i].ld_data);
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                        vecs[i].e_npc, vecs[i].e_halt);
        end

        // Index wrap: 0x3FC fetches word 255, 0x400 fetches word 0.
        drive(1'b0, 1'b0, 1'b1, 32'h3FC, 1'b0, 8'd0, 32'd0);
        step();
        check_state("wrap.br", 32'h3FC, 32'd0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
        step();
        check_state("wrap.255", 32'h400, 32'hBEEF_00FF, 32'h400, 1'b0);
        step();
        check_state("wrap.0", 32'h404, 32'h2001_0005, 32'h404, 1'b0);

        // Same-edge load write and fetch of word 5: IF/ID gets the old word.
        drive(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 8'd0, 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 8'd5, 32'h6666_6666);
        step();
        check_state("collide.old", 32'h18, 32'h5555_5555, 32'h18, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 8'd0, 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
        step();
        check_state("collide.new", 32'h18, 32'h6666_6666, 32'h18, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 8, word-index width, equal to log2(IMEM_DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port i_stall, input, 1, hazard stall; hold PC and IF/ID register.
REQ-006 SHALL have port i_branch_taken, input, 1, redirect PC and flush IF/ID.
REQ-007 SHALL have port i_branch_target, input, 32, byte address of the redirect target.
REQ-008 SHALL have port i_load_en, input, 1, instruction memory write strobe for the program loader.
REQ-009 SHALL have port i_load_addr, input, ADDR_W, word index to write.
REQ-010 SHALL have port i_load_data, input, 32, instruction word to write.
REQ-011 SHALL have port o_pc, output, 32, current PC register value.
REQ-012 SHALL have port o_next_pc, output, 32, registered PC+4 of the latched instruction, consumed by ID.
REQ-013 SHALL have port o_instruction, output, 32, registered fetched instruction, consumed by ID.
REQ-014 SHALL have port o_halted, output, 1, core halted flag.

Function
REQ-015 SHALL read the instruction memory combinationally at word index pc[ADDR_W+1:2].
- PC bits [1:0] ignored.
- Higher bits wrap modulo IMEM_DEPTH.
REQ-016 SHALL apply PC update priority per edge: reset > i_branch_taken > i_stall or halted > normal.
- Normal: pc <= pc+4, 32-bit wrap.
REQ-017 SHALL, on i_branch_taken, load pc with {i_branch_target[31:2],2'b00}, even when i_stall is high.
REQ-018 SHALL apply IF/ID register priority per edge: reset > i_branch_taken > i_stall or halted > normal.
- Flush: o_instruction <= 0 (NOP), o_next_pc <= 0.
- Stall: hold.
- Normal: o_instruction <= imem[pc], o_next_pc <= pc+4.
REQ-019 SHALL have a fetch latency of one cycle: the instruction at PC appears on o_instruction after the next rising edge.
REQ-020 SHALL, when i_load_en is high, write i_load_data to imem[i_load_addr] at the edge, independent of stall, branch, halt or reset.
REQ-021 SHALL latch the pre-write word into IF/ID when a load write and a fetch hit the same address on the same edge.
REQ-022 SHALL not clear instruction memory contents on reset.

Reset
REQ-023 SHALL, on reset, set pc=0, o_next_pc=0, o_instruction=0, o_halted=0 and halt FSM=RUN, regardless of the other inputs.
REQ-024 SHALL begin fetching address 0 on the first edge after reset deasserts.

Configuration
REQ-025 SHALL provide halt detection when macro IF_HALT_DETECT_EN is defined, using a two-state FSM:
- RUN -> HALTED when the fetched word equals 32'hFFFF_FFFF on an edge with no reset, no i_branch_taken and no i_stall.
- On that edge: IF/ID loads a NOP, pc holds at the halt address, o_halted becomes 1.
- HALTED -> RUN only on reset.
- In HALTED, i_branch_taken is ignored, and PC and IF/ID hold.
REQ-026 SHALL, without IF_HALT_DETECT_EN, fetch 32'hFFFF_FFFF as an ordinary instruction and tie o_halted to 0.

Verification
REQ-027 SHALL cover sequential fetch: load imem[0..2]=0x20010005,0x20020003,0x00221820; release reset -> o_instruction=0x20010005 with o_next_pc=4, then 0x20020003 with o_next_pc=8, then 0x00221820 with o_next_pc=12.
REQ-028 SHALL cover stall: i_stall=1 for 2 cycles with pc=8 -> o_pc stays 8 and IF/ID holds; release -> fetch resumes at 8.
REQ-029 SHALL cover branch with stall: i_branch_taken=1, i_branch_target=0x43, i_stall=1 -> next edge pc=0x40 and o_instruction=0; following edge o_instruction=imem[16], o_next_pc=0x44.
REQ-030 SHALL cover wrap: pc=0x3FC with IMEM_DEPTH=256 -> fetch imem[255]; next pc=0x400 fetches imem[0].
REQ-031 SHALL cover reset mid-run: reset at pc=0x20 during a load write -> pc=0, outputs 0, written word retained and readable after reset.
REQ-032 SHALL cover halt with IF_HALT_DETECT_EN: imem[3]=0xFFFFFFFF -> after fetch, o_halted=1, pc=12, o_instruction=0, and a later branch is ignored; without the macro o_instruction=0xFFFFFFFF and pc advances to 16.
